// File: rtl/square_motion_sequencer_pkg.sv
// Shared types and defaults for the rotating-square motion sequencer.
//   seq_state_t : sequencer phase, encoding is also the debug/LED phase output
//   *_DEF       : default tick parameters for the top level
//   run_en/run_cw/next_leg : per-phase output decode and script order
package sq_seq_pkg;

  typedef enum logic [2:0] {
    MANUAL  = 3'd0,
    CW_RUN  = 3'd1,
    PAUSE_A = 3'd2,
    CCW_RUN = 3'd3,
    PAUSE_B = 3'd4
  } seq_state_t;

  localparam int TICK_DIV_DEF    = 2**20;
  localparam int CW_TICKS_DEF    = 16;
  localparam int PAUSE_TICKS_DEF = 8;
  localparam int CCW_TICKS_DEF   = 16;

  // Rotation only during the run legs.
  function automatic logic run_en(seq_state_t s);
    return (s == CW_RUN) || (s == CCW_RUN);
  endfunction

  // Direction is kept through the pause that follows each run leg.
  function automatic logic run_cw(seq_state_t s);
    return (s == CW_RUN) || (s == PAUSE_A);
  endfunction

  function automatic seq_state_t next_leg(seq_state_t s);
    case (s)
      CW_RUN:  return PAUSE_A;
      PAUSE_A: return CCW_RUN;
      CCW_RUN: return PAUSE_B;
      default: return CW_RUN;
    endcase
  endfunction

endpackage

// File: rtl/square_motion_sequencer_if.sv
// Board-side bundle of the motion sequencer.
//   sw[1:0]    : manual controls, sw[0]=enable, sw[1]=clockwise
//   btn_mode   : raw button, rising edge toggles MANUAL/AUTO
//   btn_hold   : raw button, rising edge toggles hold while in AUTO
//   en, cw     : drive to the rotating square
//   auto_mode  : AUTO indicator, held : script frozen indicator
//   phase[2:0] : current sequencer phase
// master = board/testbench side, slave = sequencer side.
interface square_motion_sequencer_if;
  logic [1:0] sw;
  logic       btn_mode;
  logic       btn_hold;
  logic       en;
  logic       cw;
  logic       auto_mode;
  logic       held;
  logic [2:0] phase;

  modport master (output sw, btn_mode, btn_hold,
                  input  en, cw, auto_mode, held, phase);
  modport slave  (input  sw, btn_mode, btn_hold,
                  output en, cw, auto_mode, held, phase);
endinterface

// File: rtl/square_motion_sequencer_btn_edge_sync.sv
// Button conditioner: 2-FF synchronizer followed by rising-edge detect.
//   clk, reset : clock, synchronous active-high reset
//   btn_in     : raw asynchronous button level
//   pulse      : registered one-cycle pulse, 3 cycles after the pin rises
module btn_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulse
);
  logic s1_q, s2_q, prev_q, pulse_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= btn_in;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      pulse_q <= s2_q & ~prev_q;
    end
  end

  assign pulse = pulse_q;
endmodule

// File: rtl/square_motion_sequencer.sv
// Rotating-square motion sequencer. Drives en/cw either straight from the
// switches (MANUAL) or from a timed script CW_RUN -> PAUSE_A -> CCW_RUN ->
// PAUSE_B -> CW_RUN (AUTO). Buttons toggle the mode and freeze the script.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : board bundle (switches/buttons in, en/cw/LEDs/phase out)
module square_motion_sequencer
  import sq_seq_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int CW_TICKS    = CW_TICKS_DEF,
  parameter int PAUSE_TICKS = PAUSE_TICKS_DEF,
  parameter int CCW_TICKS   = CCW_TICKS_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  square_motion_sequencer_if.slave  bus
);

  localparam int MAX_LEG = (CW_TICKS > CCW_TICKS)
                           ? ((CW_TICKS > PAUSE_TICKS) ? CW_TICKS : PAUSE_TICKS)
                           : ((CCW_TICKS > PAUSE_TICKS) ? CCW_TICKS : PAUSE_TICKS);
  localparam int PW = $clog2(TICK_DIV);
  localparam int LW = (MAX_LEG < 2) ? 1 : $clog2(MAX_LEG);

  if (TICK_DIV < 2 || CW_TICKS < 1 || PAUSE_TICKS < 1 || CCW_TICKS < 1) begin : g_bad_param
    $error("square_motion_sequencer: TICK_DIV must be >=2 and all *_TICKS >=1");
  end

  logic mode_p, hold_p;

  btn_edge_sync u_mode_sync (
    .clk    (clk),
    .reset  (reset),
    .btn_in (bus.btn_mode),
    .pulse  (mode_p)
  );

  btn_edge_sync u_hold_sync (
    .clk    (clk),
    .reset  (reset),
    .btn_in (bus.btn_hold),
    .pulse  (hold_p)
  );

  seq_state_t    state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [LW-1:0] leg_q;
  logic          en_q, cw_q, auto_q, held_q;
  logic          tick, leg_last;

  function automatic int leg_len(seq_state_t s);
    case (s)
      CW_RUN:  return CW_TICKS;
      CCW_RUN: return CCW_TICKS;
      default: return PAUSE_TICKS;
    endcase
  endfunction

  always_comb begin
    tick     = (presc_q == PW'(TICK_DIV - 1));
    leg_last = (int'(leg_q) == leg_len(state_q) - 1);
    state_d  = next_leg(state_q);
  end

  // Single FSM: mode pulse has priority over hold, so a simultaneous pair
  // leaves via the mode branch and the hold pulse is dropped. A hold toggle
  // edge never advances the counters, so unhold resumes exactly in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MANUAL;
      presc_q <= '0;
      leg_q   <= '0;
      en_q    <= 1'b0;
      cw_q    <= 1'b0;
      auto_q  <= 1'b0;
      held_q  <= 1'b0;
    end else if (mode_p) begin
      presc_q <= '0;
      leg_q   <= '0;
      held_q  <= 1'b0;
      if (state_q == MANUAL) begin
        state_q <= CW_RUN;
        en_q    <= 1'b1;
        cw_q    <= 1'b1;
        auto_q  <= 1'b1;
      end else begin
        state_q <= MANUAL;
        en_q    <= bus.sw[0];
        cw_q    <= bus.sw[1];
        auto_q  <= 1'b0;
      end
    end else if (state_q == MANUAL) begin
      presc_q <= '0;
      leg_q   <= '0;
      en_q    <= bus.sw[0];
      cw_q    <= bus.sw[1];
    end else if (hold_p) begin
      held_q  <= ~held_q;
      en_q    <= held_q ? run_en(state_q) : 1'b0;
    end else if (!held_q) begin
      if (tick) begin
        presc_q <= '0;
        if (leg_last) begin
          leg_q   <= '0;
          state_q <= state_d;
          en_q    <= run_en(state_d);
          cw_q    <= run_cw(state_d);
        end else begin
          leg_q   <= leg_q + 1'b1;
        end
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  assign bus.en        = en_q;
  assign bus.cw        = cw_q;
  assign bus.auto_mode = auto_q;
  assign bus.held      = held_q;
  assign bus.phase     = state_q;

endmodule

// File: tb/tb_square_motion_sequencer.sv
module tb_square_motion_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  square_motion_sequencer_if bus ();

  square_motion_sequencer #(
    .TICK_DIV    (4),
    .CW_TICKS    (3),
    .PAUSE_TICKS (2),
    .CCW_TICKS   (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         at;
    string      name;
    logic [2:0] ph;
    logic       en, cw, au, hd;
  } exp_t;

  exp_t sb[$];

  task automatic expect_at(input int at, input string name, input int ph,
                           input bit en, input bit cw, input bit au, input bit hd);
    exp_t e;
    e.at = at; e.name = name; e.ph = 3'(ph);
    e.en = en; e.cw = cw; e.au = au; e.hd = hd;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: outputs sampled on the falling edge, entry checked in the
  // cycle it was scheduled for.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if (e.at < cyc)
        $display("FAIL %s: scheduled cyc %0d never sampled (now %0d)", e.name, e.at, cyc);
      else if (bus.phase !== e.ph || bus.en !== e.en || bus.cw !== e.cw ||
               bus.auto_mode !== e.au || bus.held !== e.hd)
        $display("FAIL %s @cyc %0d: got ph=%0d en=%b cw=%b auto=%b held=%b, want ph=%0d en=%b cw=%b auto=%b held=%b",
                 e.name, cyc, bus.phase, bus.en, bus.cw, bus.auto_mode, bus.held,
                 e.ph, e.en, e.cw, e.au, e.hd);
      else
        n_pass++;
    end
  end

  initial begin
    reset        = 1'b1;
    bus.sw       = 2'b11;
    bus.btn_mode = 1'b0;
    bus.btn_hold = 1'b0;

    // 1: reset for two edges, switches follow one cycle after release
    expect_at(1, "rst_c1",   0, 0, 0, 0, 0);
    expect_at(2, "rst_c2",   0, 0, 0, 0, 0);
    expect_at(3, "man_sw11", 0, 1, 1, 0, 0);
    wait_until(2);
    reset = 1'b0;

    // 2: full AUTO period, 12/8/12/8 cycles
    wait_until(5);
    bus.btn_mode = 1'b1;
    expect_at(8,  "pre_mode",  0, 1, 1, 0, 0);
    expect_at(9,  "cw_enter",  1, 1, 1, 1, 0);
    expect_at(20, "cw_last",   1, 1, 1, 1, 0);
    expect_at(21, "pa_enter",  2, 0, 1, 1, 0);
    expect_at(28, "pa_last",   2, 0, 1, 1, 0);
    expect_at(29, "ccw_enter", 3, 1, 0, 1, 0);
    expect_at(40, "ccw_last",  3, 1, 0, 1, 0);
    expect_at(41, "pb_enter",  4, 0, 0, 1, 0);
    expect_at(48, "pb_last",   4, 0, 0, 1, 0);
    expect_at(49, "cw_wrap",   1, 1, 1, 1, 0);
    wait_until(7);
    bus.btn_mode = 1'b0;

    // 3: hold at leg count 1 for 20 cycles, then remaining 8 cycles of CW_RUN
    wait_until(50);
    bus.btn_hold = 1'b1;
    expect_at(53, "pre_hold",   1, 1, 1, 1, 0);
    expect_at(54, "hold_on",    1, 0, 1, 1, 1);
    expect_at(73, "hold_last",  1, 0, 1, 1, 1);
    expect_at(74, "unhold",     1, 1, 1, 1, 0);
    expect_at(81, "resume_cw",  1, 1, 1, 1, 0);
    expect_at(82, "resume_pa",  2, 0, 1, 1, 0);
    wait_until(52);
    bus.btn_hold = 1'b0;
    wait_until(70);
    bus.btn_hold = 1'b1;
    wait_until(72);
    bus.btn_hold = 1'b0;

    // 4: hold in PAUSE_A, then mode+hold together -> MANUAL, held cleared
    wait_until(84);
    bus.sw       = 2'b01;
    bus.btn_hold = 1'b1;
    expect_at(88, "pa_hold",    2, 0, 1, 1, 1);
    expect_at(93, "pa_frozen",  2, 0, 1, 1, 1);
    expect_at(94, "both_man",   0, 1, 0, 0, 0);
    expect_at(95, "both_sw01",  0, 1, 0, 0, 0);
    wait_until(86);
    bus.btn_hold = 1'b0;
    wait_until(90);
    bus.btn_mode = 1'b1;
    bus.btn_hold = 1'b1;
    wait_until(92);
    bus.btn_mode = 1'b0;
    bus.btn_hold = 1'b0;

    // 5: hold button pressed long in MANUAL is ignored
    wait_until(97);
    bus.sw       = 2'b10;
    bus.btn_hold = 1'b1;
    expect_at(98,  "man_sw10",  0, 0, 1, 0, 0);
    expect_at(101, "man_hold",  0, 0, 1, 0, 0);
    expect_at(150, "man_hold2", 0, 0, 1, 0, 0);
    expect_at(197, "man_hold3", 0, 0, 1, 0, 0);
    wait_until(197);
    bus.btn_hold = 1'b0;

    // 6: reset in CCW_RUN while held, with a mode edge still in the synchronizer
    wait_until(200);
    bus.sw       = 2'b11;
    bus.btn_mode = 1'b1;
    expect_at(201, "man_sw11b", 0, 1, 1, 0, 0);
    expect_at(204, "auto2",     1, 1, 1, 1, 0);
    expect_at(224, "ccw2",      3, 1, 0, 1, 0);
    expect_at(225, "ccw2_b",    3, 1, 0, 1, 0);
    expect_at(226, "ccw_hold",  3, 0, 0, 1, 1);
    expect_at(234, "ccw_froz",  3, 0, 0, 1, 1);
    expect_at(236, "rst_mid",   0, 0, 0, 0, 0);
    expect_at(237, "post_rst",  0, 1, 1, 0, 0);
    expect_at(245, "post_rst2", 0, 1, 1, 0, 0);
    wait_until(222);
    bus.btn_hold = 1'b1;
    wait_until(224);
    bus.btn_hold = 1'b0;
    wait_until(229);
    bus.btn_mode = 1'b0;
    wait_until(234);
    bus.btn_mode = 1'b1;
    wait_until(235);
    reset        = 1'b1;
    bus.btn_mode = 1'b0;
    wait_until(236);
    reset = 1'b0;

    wait_until(247);
    n_chk++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
